relu_share_arb: RTL and testbench

RELU_SHARE_ARB -- requirements
Module: relu_share_arb

---
 rtl/relu_share_arb.sv | 131 +++++++++++++
 tb/tb_relu_share_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_share_arb.sv
// Two-requester arbiter sharing one pipelined ReLU unit. Grants whole bursts round-robin
// and routes each result back to the requester that issued it using a latency-matched tag pipe.
module relu_share_arb #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RELU_LAT   = 1,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  input  logic                  req1_last,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] relu_in_data,
  output logic                  relu_in_valid,
  input  logic [DATA_WIDTH-1:0] relu_out_data,
  input  logic                  relu_out_valid,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  output logic [1:0]            owner,
  output logic                  err_overrun,
  output logic                  err_sync
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrant0 = 2'b01,
    StGrant1 = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              last_served_q, last_served_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_sync_q, err_sync_d;
  // Each tag entry is {valid, owner}; owner 1 means requester 1.
  logic [1:0]        tag_q [RELU_LAT];

  logic              cur_last;
  logic              tail_valid;
  logic              tail_owner;
  logic              route;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
      err_overrun_q <= 1'b0;
      err_sync_q    <= 1'b0;
      for (int unsigned i = 0; i < RELU_LAT; i++) begin
        tag_q[i] <= 2'b00;
      end
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_cnt_q    <= beat_cnt_d;
      err_overrun_q <= err_overrun_d;
      err_sync_q    <= err_sync_d;
      tag_q[0]      <= {relu_in_valid, req1_ready};
      for (int unsigned i = 1; i < RELU_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    beat_cnt_d    = beat_cnt_q;
    err_overrun_d = err_overrun_q;
    err_sync_d    = err_sync_q | (relu_out_valid != tail_valid);
    cur_last      = (state_q == StGrant1) ? req1_last : req0_last;
    unique case (state_q)
      StIdle: begin
        beat_cnt_d = '0;
        if (req0_valid && (!req1_valid || last_served_q)) begin
          state_d = StGrant0;
        end else if (req1_valid) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        if (relu_in_valid) begin
          if (cur_last) begin
            state_d       = StIdle;
            last_served_d = (state_q == StGrant1);
          end else if (beat_cnt_q + CntW'(1) == CntW'(MAX_BURST)) begin
            // Burst ran too long without a last beat: force rearbitration.
            state_d       = StIdle;
            last_served_d = (state_q == StGrant1);
            err_overrun_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are also gated by rst so nothing leaks out during a reset cycle.
  always_comb begin
    req0_ready    = (state_q == StGrant0) && !rst;
    req1_ready    = (state_q == StGrant1) && !rst;
    relu_in_valid = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    relu_in_data  = '0;
    if (relu_in_valid) begin
      relu_in_data = req1_ready ? req1_data : req0_data;
    end
    tail_valid = tag_q[RELU_LAT-1][1];
    tail_owner = tag_q[RELU_LAT-1][0];
    route      = tail_valid && relu_out_valid && !rst;
    out0_valid = route && !tail_owner;
    out1_valid = route && tail_owner;
    out0_data  = out0_valid ? relu_out_data : '0;
    out1_data  = out1_valid ? relu_out_data : '0;
    owner       = state_q;
    err_overrun = err_overrun_q;
    err_sync    = err_sync_q;
  end

endmodule

// File: tb/tb_relu_share_arb.sv
// Scoreboard bench for relu_share_arb with a one-cycle behavioural ReLU (max(x,0)).
// Issued beats are predicted into a queue and popped as routed results appear.
module tb_relu_share_arb;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [DW-1:0] req0_data, req1_data;
  logic req0_valid, req0_last, req0_ready;
  logic req1_valid, req1_last, req1_ready;
  logic [DW-1:0] relu_in_data, relu_out_data, out0_data, out1_data;
  logic relu_in_valid, relu_out_valid, out0_valid, out1_valid;
  logic [1:0] owner;
  logic err_overrun, err_sync;

  relu_share_arb #(
    .DATA_WIDTH(DW),
    .RELU_LAT  (1),
    .MAX_BURST (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_data     (req0_data),
    .req0_valid    (req0_valid),
    .req0_last     (req0_last),
    .req0_ready    (req0_ready),
    .req1_data     (req1_data),
    .req1_valid    (req1_valid),
    .req1_last     (req1_last),
    .req1_ready    (req1_ready),
    .relu_in_data  (relu_in_data),
    .relu_in_valid (relu_in_valid),
    .relu_out_data (relu_out_data),
    .relu_out_valid(relu_out_valid),
    .out0_data     (out0_data),
    .out0_valid    (out0_valid),
    .out1_data     (out1_data),
    .out1_valid    (out1_valid),
    .owner         (owner),
    .err_overrun   (err_overrun),
    .err_sync      (err_sync)
  );

  // Behavioural ReLU, one cycle of latency; inj forces a spurious result valid.
  logic          relu_v_q = 1'b0;
  logic [DW-1:0] relu_d_q = '0;
  logic          inj;
  always @(posedge clk) begin
    relu_v_q <= relu_in_valid;
    relu_d_q <= ($signed(relu_in_data) > 0) ? relu_in_data : '0;
  end
  assign relu_out_valid = relu_v_q | inj;
  assign relu_out_data  = relu_d_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic port; logic [DW-1:0] data;} exp_t;
  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;

  exp_t  sb[$];
  beat_t q0[$], q1[$];
  int    xfer_port[$], xfer_cyc[$], out_cyc0[$], out_cyc1[$];
  logic [3:0] owner_seen;
  int    own_at9;
  int    n_cmp = 0;
  int    n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic signed [DW-1:0] x);
    return (x > 0) ? x : '0;
  endfunction

  // Monitor: predict on transfer, compare on routed output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        owner_seen[owner] = 1'b1;
        if (req0_valid && req0_ready) begin
          sb.push_back({1'b0, relu(req0_data)});
          xfer_port.push_back(0);
          xfer_cyc.push_back(cyc);
        end
        if (req1_valid && req1_ready) begin
          sb.push_back({1'b1, relu(req1_data)});
          xfer_port.push_back(1);
          xfer_cyc.push_back(cyc);
        end
        if (out0_valid || out1_valid) begin
          check("out_onehot", {31'd0, out0_valid & out1_valid}, 0);
          if (sb.size() == 0) begin
            check("unexpected_out", {30'd0, out1_valid, out0_valid}, 0);
          end else begin
            e = sb.pop_front();
            check("out_port", {31'd0, out1_valid}, {31'd0, e.port});
            check("out_data", out1_valid ? out1_data : out0_data, e.data);
          end
          if (out0_valid) begin
            out_cyc0.push_back(cyc);
            if (out0_data == 16'd9) own_at9 = owner;
          end
          if (out1_valid) out_cyc1.push_back(cyc);
        end
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic [DW-1:0] d, input logic l);
    if (p == 0) begin
      req0_valid = v; req0_data = d; req0_last = l;
    end else begin
      req1_valid = v; req1_data = d; req1_last = l;
    end
  endtask

  // Present the port's queued beats back to back, waiting for ready on each.
  task automatic run_port(input int p);
    beat_t b;
    int    guard;
    while ((p == 0 ? q0.size() : q1.size()) != 0) begin
      b = (p == 0) ? q0[0] : q1[0];
      set_req(p, 1'b1, b.data, b.last);
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!(p == 0 ? req0_ready : req1_ready) && guard < 50);
      if (guard >= 50) begin
        check("ready_timeout", guard, 0);
        if (p == 0) q0.delete(); else q1.delete();
      end else begin
        @(posedge clk);
        #1;
        if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    set_req(p, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inj = 1'b0;
    set_req(0, 1'b0, '0, 1'b0);
    set_req(1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_outputs", {27'd0, req0_ready, req1_ready, relu_in_valid, out0_valid, out1_valid}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_owner", owner, 0);
    check("rst_errs", {30'd0, err_overrun, err_sync}, 0);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
    xfer_port.delete(); xfer_cyc.delete(); out_cyc0.delete(); out_cyc1.delete();
    owner_seen = '0;
    own_at9    = -1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rise, n0;
    int exp_port[6];
    int exp_gap[5];

    // Single requester burst.
    do_reset();
    q0 = '{'{16'hFFFB, 1'b0}, '{16'd0, 1'b0}, '{16'd7, 1'b0}, '{16'hFFFE, 1'b1}};
    rise = cyc;
    run_port(0);
    repeat (4) @(negedge clk);
    check("s1_n_out0", out_cyc0.size(), 4);
    check("s1_n_out1", out_cyc1.size(), 0);
    if (out_cyc0.size() == 4) begin
      check("s1_latency", out_cyc0[0] - rise, 2);
      check("s1_consecutive", out_cyc0[3] - out_cyc0[0], 3);
    end
    check("s1_owner_seen", owner_seen, 4'b0011);
    check("s1_owner_end", owner, 0);

    // Contention: two requesters, 2-beat bursts.
    do_reset();
    q0 = '{'{16'd10, 1'b0}, '{16'd11, 1'b1}, '{16'd12, 1'b0}, '{16'd13, 1'b1}};
    q1 = '{'{16'hFFEC, 1'b0}, '{16'd21, 1'b1}};
    fork
      run_port(0);
      run_port(1);
    join
    repeat (4) @(negedge clk);
    exp_port = '{0, 0, 1, 1, 0, 0};
    exp_gap  = '{1, 2, 1, 2, 1};
    check("s2_n_xfer", xfer_port.size(), 6);
    if (xfer_port.size() == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("s2_port%0d", i), xfer_port[i], exp_port[i]);
      for (int i = 0; i < 5; i++)
        check($sformatf("s2_gap%0d", i), xfer_cyc[i+1] - xfer_cyc[i], exp_gap[i]);
    end
    if (out_cyc1.size() > 0 && out_cyc0.size() > 1)
      check("s2_out1_after_out0", {31'd0, out_cyc1[0] > out_cyc0[1]}, 1);
    check("s2_sb_empty", sb.size(), 0);

    // Handover with a result still in flight.
    do_reset();
    q0 = '{'{16'd9, 1'b1}};
    q1 = '{'{16'd4, 1'b1}};
    fork
      run_port(0);
      begin
        @(posedge clk);
        #1;
        run_port(1);
      end
    join
    repeat (4) @(negedge clk);
    check("s3_n_out0", out_cyc0.size(), 1);
    check("s3_n_out1", out_cyc1.size(), 1);
    check("s3_owner_moved", {31'd0, own_at9 == 0 || own_at9 == 2}, 1);
    if (xfer_cyc.size() == 2) check("s3_handover_gap", xfer_cyc[1] - xfer_cyc[0], 2);

    // Overrun: 6 beats without last, MAX_BURST=4.
    do_reset();
    for (int i = 0; i < 6; i++) q1.push_back('{16'(100 + i), 1'b0});
    run_port(1);
    repeat (4) @(negedge clk);
    check("s4_n_xfer", xfer_cyc.size(), 6);
    if (xfer_cyc.size() == 6) begin
      exp_gap = '{1, 1, 1, 2, 1};
      for (int i = 0; i < 5; i++)
        check($sformatf("s4_gap%0d", i), xfer_cyc[i+1] - xfer_cyc[i], exp_gap[i]);
    end
    check("s4_err_overrun", err_overrun, 1);
    check("s4_err_sync", err_sync, 0);
    check("s4_n_out1", out_cyc1.size(), 6);

    // Spurious ReLU valid with nothing issued.
    do_reset();
    inj = 1'b1;
    @(negedge clk);
    check("s5_no_out", {30'd0, out0_valid, out1_valid}, 0);
    @(posedge clk);
    #1 inj = 1'b0;
    @(negedge clk);
    check("s5_err_sync", err_sync, 1);
    repeat (3) @(negedge clk);
    check("s5_err_sticky", err_sync, 1);
    check("s5_n_out", out_cyc0.size() + out_cyc1.size(), 0);
    do_reset();
    check("s5_err_cleared", err_sync, 0);

    // Reset during the second beat of a four-beat burst.
    set_req(0, 1'b1, 16'd1, 1'b0);
    n0 = 0;
    while (!req0_ready && n0 < 10) begin
      @(negedge clk);
      n0++;
    end
    check("s6_granted", req0_ready, 1);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 16'd2, 1'b0);
    rst = 1'b1;
    n0  = out_cyc0.size();
    @(negedge clk);
    check("s6_ready_in_rst", req0_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("s6_owner", owner, 0);
    check("s6_ready", req0_ready, 0);
    repeat (3) @(negedge clk);
    check("s6_no_output", out_cyc0.size() - n0, 0);
    check("s6_err_sync", err_sync, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
